// File: rtl/conv1d_cmd_sequencer.sv
// Initiator for the conv1d CFU command interface: sends parameters, streams filter/input bytes,
// polls for completion and returns the result. Define CFU_SEQ_TIMEOUT_EN to bound the poll loop.
module conv1d_cmd_sequencer #(
    parameter int KERNEL_LENGTH = 8,
`ifdef CFU_SEQ_TIMEOUT_EN
    parameter int POLL_LIMIT    = 4096,
`endif
    parameter int MAX_DEPTH     = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_sel,
    input  logic [31:0] cfg_data,
    input  logic        job_start,
    input  logic        job_ld_filt,
    input  logic [10:0] job_in_base,
    input  logic [10:0] job_in_count,
    output logic        job_ready,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        cfu_en,
    output logic [6:0]  cfu_cmd,
    output logic [31:0] cfu_inp0,
    output logic [31:0] cfu_inp1,
    input  logic [31:0] cfu_ret,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        job_err
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PARAMS, ST_LD_FILT, ST_LD_IN, ST_START,
        ST_POLL_ISS, ST_POLL_WAIT, ST_RD_ISS, ST_RD_WAIT, ST_RESULT
    } state_t;

    // Responder command code for each shadow register, in issue order.
    function automatic logic [6:0] param_cmd(input logic [3:0] idx);
        case (idx)
            4'd0:    param_cmd = 7'd3;
            4'd1:    param_cmd = 7'd5;
            4'd2:    param_cmd = 7'd8;
            4'd3:    param_cmd = 7'd12;
            4'd4:    param_cmd = 7'd13;
            4'd5:    param_cmd = 7'd14;
            4'd6:    param_cmd = 7'd15;
            4'd7:    param_cmd = 7'd16;
            4'd8:    param_cmd = 7'd17;
            default: param_cmd = 7'd0;
        endcase
    endfunction

    state_t      state_r, state_n, after_filt_s, after_params_s;
    logic [31:0] shadow_r  [0:8];
    logic [31:0] job_par_r [0:8];
    logic        ld_filt_r;
    logic [10:0] in_count_r, in_addr_r, filt_len_r, k_r;
    logic [3:0]  idx_r;
    logic        res_valid_r, job_err_r;
    logic [31:0] res_data_r;

    logic        depth_ok_s, accept_s, beat_s, timeout_s;
    logic [10:0] start_len_s, len_div_s, first_addr_s;
    logic        cfu_en_s;
    logic [6:0]  cfu_cmd_s;
    logic [31:0] cfu_inp0_s, cfu_inp1_s;

    assign depth_ok_s     = (shadow_r[1] != 32'd0) && (shadow_r[1] <= 32'(MAX_DEPTH));
    assign start_len_s    = shadow_r[1][10:0] * 11'(KERNEL_LENGTH);
    assign len_div_s      = depth_ok_s ? start_len_s : 11'd1;
    // A base past the ring end folds back into it.
    assign first_addr_s   = job_in_base % len_div_s;
    assign accept_s       = (state_r == ST_IDLE) && job_start && depth_ok_s;
    assign s_ready        = (state_r == ST_LD_FILT) || (state_r == ST_LD_IN);
    assign beat_s         = s_valid && s_ready;
    assign after_filt_s   = (in_count_r != 11'd0) ? ST_LD_IN : ST_START;
    assign after_params_s = ld_filt_r ? ST_LD_FILT : after_filt_s;

    assign job_ready = (state_r == ST_IDLE);
    assign cfu_en    = cfu_en_s;
    assign cfu_cmd   = cfu_cmd_s;
    assign cfu_inp0  = cfu_inp0_s;
    assign cfu_inp1  = cfu_inp1_s;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign job_err   = job_err_r;

`ifdef CFU_SEQ_TIMEOUT_EN
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    logic [POLL_W-1:0] poll_cnt_r;

    // Count unfinished polls of the current job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt_r <= '0;
        end else if (accept_s) begin
            poll_cnt_r <= '0;
        end else if ((state_r == ST_POLL_WAIT) && !cfu_ret[0]) begin
            poll_cnt_r <= poll_cnt_r + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_n;
    end

    // Next state and the command presented to the responder this cycle.
    always_comb begin
        state_n    = state_r;
        cfu_en_s   = 1'b0;
        cfu_cmd_s  = 7'd0;
        cfu_inp0_s = 32'd0;
        cfu_inp1_s = 32'd0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_n = ST_PARAMS;
                else          state_n = ST_IDLE;
            end
            ST_PARAMS: begin
                cfu_en_s   = 1'b1;
                cfu_cmd_s  = param_cmd(idx_r);
                cfu_inp1_s = job_par_r[idx_r];
                if (idx_r == 4'd8) state_n = after_params_s;
                else               state_n = ST_PARAMS;
            end
            ST_LD_FILT: begin
                if (s_valid) begin
                    cfu_en_s   = 1'b1;
                    cfu_cmd_s  = 7'd2;
                    cfu_inp0_s = {21'd0, k_r};
                    cfu_inp1_s = {{24{s_data[7]}}, s_data};
                    if (k_r == filt_len_r - 11'd1) state_n = after_filt_s;
                    else                           state_n = ST_LD_FILT;
                end else begin
                    state_n = ST_LD_FILT;
                end
            end
            ST_LD_IN: begin
                if (s_valid) begin
                    cfu_en_s   = 1'b1;
                    cfu_cmd_s  = 7'd1;
                    cfu_inp0_s = {21'd0, in_addr_r};
                    cfu_inp1_s = {{24{s_data[7]}}, s_data};
                    if (in_count_r == 11'd1) state_n = ST_START;
                    else                     state_n = ST_LD_IN;
                end else begin
                    state_n = ST_LD_IN;
                end
            end
            ST_START: begin
                cfu_en_s  = 1'b1;
                cfu_cmd_s = 7'd6;
                state_n   = ST_POLL_ISS;
            end
            ST_POLL_ISS: begin
                cfu_en_s  = 1'b1;
                cfu_cmd_s = 7'd9;
                state_n   = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (cfu_ret[0]) begin
                    state_n = ST_RD_ISS;
                end else begin
`ifdef CFU_SEQ_TIMEOUT_EN
                    if (poll_cnt_r == POLL_W'(POLL_LIMIT - 1)) begin
                        timeout_s = 1'b1;
                        state_n   = ST_RESULT;
                    end else begin
                        state_n = ST_POLL_ISS;
                    end
`else
                    state_n = ST_POLL_ISS;
`endif
                end
            end
            ST_RD_ISS: begin
                cfu_en_s  = 1'b1;
                cfu_cmd_s = 7'd7;
                state_n   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_n = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) state_n = ST_IDLE;
                else           state_n = ST_RESULT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Shadow registers are writable at any time; a job works from its own snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 9; i++) shadow_r[i] <= 32'd0;
        end else if (cfg_we && (cfg_sel <= 4'd8)) begin
            shadow_r[cfg_sel] <= cfg_data;
        end
    end

    // Job snapshot, parameter index and stream address counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 9; i++) job_par_r[i] <= 32'd0;
            ld_filt_r  <= 1'b0;
            in_count_r <= 11'd0;
            in_addr_r  <= 11'd0;
            filt_len_r <= 11'd0;
            k_r        <= 11'd0;
            idx_r      <= 4'd0;
        end else if (accept_s) begin
            for (int i = 0; i < 9; i++) job_par_r[i] <= shadow_r[i];
            ld_filt_r  <= job_ld_filt;
            in_count_r <= job_in_count;
            in_addr_r  <= first_addr_s;
            filt_len_r <= start_len_s;
            k_r        <= 11'd0;
            idx_r      <= 4'd0;
        end else begin
            if (state_r == ST_PARAMS) idx_r <= idx_r + 4'd1;
            if ((state_r == ST_LD_FILT) && beat_s) k_r <= k_r + 11'd1;
            if ((state_r == ST_LD_IN) && beat_s) begin
                in_count_r <= in_count_r - 11'd1;
                in_addr_r  <= (in_addr_r == filt_len_r - 11'd1) ? 11'd0 : in_addr_r + 11'd1;
            end
        end
    end

    // Result holding register and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 32'd0;
            job_err_r   <= 1'b0;
        end else begin
            if (accept_s)
                job_err_r <= 1'b0;
            else if ((state_r == ST_IDLE) && job_start && !depth_ok_s)
                job_err_r <= 1'b1;
            else if (timeout_s)
                job_err_r <= 1'b1;

            if (timeout_s) begin
                res_data_r  <= 32'd0;
                res_valid_r <= 1'b1;
            end else if (state_r == ST_RD_WAIT) begin
                res_data_r  <= cfu_ret;
                res_valid_r <= 1'b1;
            end else if ((state_r == ST_RESULT) && res_ready) begin
                res_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_cmd_sequencer.sv
// Randomized bench for conv1d_cmd_sequencer with a responder stub and a command-list reference model.
`timescale 1ns/1ps
module tb_conv1d_cmd_sequencer;
`ifdef CFU_SEQ_TIMEOUT_EN
    localparam int PL = 4;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_sel = 4'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        job_start = 1'b0, job_ld_filt = 1'b0;
    logic [10:0] job_in_base = 11'd0, job_in_count = 11'd0;
    logic        job_ready;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready, cfu_en;
    logic [6:0]  cfu_cmd;
    logic [31:0] cfu_inp0, cfu_inp1;
    logic [31:0] cfu_ret = 32'd0;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready = 1'b0;
    logic        job_err;

`ifdef CFU_SEQ_TIMEOUT_EN
    conv1d_cmd_sequencer #(.POLL_LIMIT(PL)) dut (
`else
    conv1d_cmd_sequencer dut (
`endif
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .job_start(job_start), .job_ld_filt(job_ld_filt), .job_in_base(job_in_base),
        .job_in_count(job_in_count), .job_ready(job_ready), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .cfu_en(cfu_en), .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0),
        .cfu_inp1(cfu_inp1), .cfu_ret(cfu_ret), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .job_err(job_err)
    );

    initial forever #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [70:0] obs_q[$];
    int          poll_seen = 0;
    int          npoll_m = 0;
    int          idle_bad = 0;
    logic [31:0] rd_val_m = 32'd0;
    logic [31:0] ret_next = 32'd0;
    logic [31:0] shadow_m[9];
    int          pc[9] = '{3, 5, 8, 12, 13, 14, 15, 16, 17};

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Responder stub: records commands; the return is valid in the cycle after each command.
    initial forever begin
        @(negedge clk);
        ret_next = $urandom;
        if (cfu_en) begin
            obs_q.push_back({cfu_cmd, cfu_inp0, cfu_inp1});
            if (cfu_cmd == 7'd6) poll_seen = 0;
            if (cfu_cmd == 7'd9) begin
                poll_seen++;
                ret_next[0] = (poll_seen > npoll_m);
            end
            if (cfu_cmd == 7'd7) ret_next = rd_val_m;
        end else if ((cfu_cmd != 7'd0) || (cfu_inp0 != 32'd0) || (cfu_inp1 != 32'd0)) begin
            idle_bad++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        cfu_ret = ret_next;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] sel, input logic [31:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        if (sel <= 4'd8) shadow_m[sel] = d;
    endtask

    task automatic bad_depth_job(input logic [31:0] d);
        int n0;
        cfg_write(4'd1, d);
        obs_q.delete();
        check_eq("bad_ready_pre", job_ready, 1'b1);
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        check_eq("bad_err", job_err, 1'b1);
        check_eq("bad_ready", job_ready, 1'b1);
        n0 = obs_q.size();
        repeat (4) tick();
        check_eq("bad_no_cmd", obs_q.size() + n0, 0);
    endtask

    task automatic run_job(input int depth, input bit ld, input int base, input int cnt,
                           input int npoll, input logic [31:0] rd_val,
                           input bit gaps, input bit toggle, input bit ack_start);
        logic [70:0] exp_q[$];
        logic [7:0]  bytes[$];
        logic [31:0] snap[9];
        logic [31:0] exp_res;
        bit          exp_err, to;
        int          len, nfilt, a0, nmin;
        for (int i = 0; i < 9; i++) cfg_write(4'(i), (i == 1) ? 32'(depth) : $urandom);
        cfg_write(4'(9 + $urandom_range(0, 6)), $urandom);
        snap = shadow_m;
        len = 8 * depth;
        nfilt = ld ? len : 0;
        for (int i = 0; i < nfilt + cnt; i++) bytes.push_back(8'($urandom));
        for (int i = 0; i < 9; i++) exp_q.push_back({7'(pc[i]), 32'd0, snap[i]});
        for (int k = 0; k < nfilt; k++) exp_q.push_back({7'd2, 32'(k), sext(bytes[k])});
        a0 = base % len;
        for (int i = 0; i < cnt; i++)
            exp_q.push_back({7'd1, 32'((a0 + i) % len), sext(bytes[nfilt + i])});
        exp_q.push_back({7'd6, 32'd0, 32'd0});
        to = 1'b0;
`ifdef CFU_SEQ_TIMEOUT_EN
        if (npoll >= PL) to = 1'b1;
        if (to) begin
            repeat (PL) exp_q.push_back({7'd9, 32'd0, 32'd0});
        end
`endif
        if (!to) begin
            repeat (npoll + 1) exp_q.push_back({7'd9, 32'd0, 32'd0});
            exp_q.push_back({7'd7, 32'd0, 32'd0});
        end
        exp_err = to;
        exp_res = to ? 32'd0 : rd_val;
        npoll_m = npoll; rd_val_m = rd_val;
        obs_q.delete(); idle_bad = 0;

        check_eq("ready_pre", job_ready, 1'b1);
        job_start = 1'b1; job_ld_filt = ld;
        job_in_base = 11'(base); job_in_count = 11'(cnt);
        tick();
        job_start = 1'b0;
        check_eq("ready_busy", job_ready, 1'b0);
        check_eq("err_clr", job_err, 1'b0);

        fork
            begin : stream
                int w;
                for (int i = 0; i < nfilt + cnt; i++) begin
                    if (toggle || (gaps && ($urandom_range(0, 2) == 0))) begin
                        s_valid = 1'b0; s_data = 8'($urandom);
                        tick();
                    end
                    s_valid = 1'b1; s_data = bytes[i];
                    w = 0;
                    while (!s_ready && (w < 200)) begin tick(); w++; end
                    if (!s_ready) begin
                        check_eq("s_ready_wait", s_ready, 1'b1);
                        break;
                    end
                    tick();
                end
                s_valid = 1'b0;
            end
            begin : result
                int w, n0;
                w = 0;
                while (!res_valid && (w < 20000)) begin tick(); w++; end
                check_eq("res_valid", res_valid, 1'b1);
                if (res_valid) begin
                    for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                        check_eq("res_hold", res_valid, 1'b1);
                        tick();
                    end
                    check_eq("res_data", res_data, exp_res);
                    check_eq("job_err", job_err, exp_err);
                    check_eq("ready_in_result", job_ready, 1'b0);
                    res_ready = 1'b1;
                    if (ack_start) job_start = 1'b1;
                    tick();
                    res_ready = 1'b0; job_start = 1'b0;
                    check_eq("res_drop", res_valid, 1'b0);
                    check_eq("ready_after", job_ready, 1'b1);
                    if (ack_start) begin
                        n0 = obs_q.size();
                        repeat (3) tick();
                        check_eq("start_ignored", obs_q.size(), n0);
                        check_eq("start_ignored_rdy", job_ready, 1'b1);
                    end
                end
            end
            begin : midjob_cfg
                repeat (3) tick();
                cfg_write(4'($urandom_range(0, 8)), $urandom);
            end
        join

        check_eq("n_cmds", obs_q.size(), exp_q.size());
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) check_eq($sformatf("cmd[%0d]", i), obs_q[i], exp_q[i]);
        check_eq("idle_zero", idle_bad, 0);
    endtask

    task automatic reset_in_poll();
        int  w, n0;
        bit  found;
        for (int i = 0; i < 9; i++) cfg_write(4'(i), (i == 1) ? 32'd2 : $urandom);
        obs_q.delete();
        npoll_m = 100000;
        job_start = 1'b1; job_ld_filt = 1'b0; job_in_base = 11'd0; job_in_count = 11'd0;
        tick();
        job_start = 1'b0;
        w = 0; found = 1'b0;
        while (!found && (w < 100)) begin
            tick(); w++;
            if (obs_q.size() > 0) found = (obs_q[obs_q.size() - 1][70:64] == 7'd9);
        end
        check_eq("reach_poll", found, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_cfu_en", cfu_en, 1'b0);
        check_eq("rst_s_ready", s_ready, 1'b0);
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_data", res_data, 32'd0);
        check_eq("rst_job_err", job_err, 1'b0);
        check_eq("rst_job_ready", job_ready, 1'b1);
        n0 = obs_q.size();
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) shadow_m[i] = 32'd0;
        repeat (4) tick();
        check_eq("rst_no_cmd", obs_q.size(), n0);
        check_eq("rst_ready_after", job_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) shadow_m[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_job_ready", job_ready, 1'b1);
        check_eq("reset_cfu_en", cfu_en, 1'b0);
        check_eq("reset_s_ready", s_ready, 1'b0);
        check_eq("reset_res_valid", res_valid, 1'b0);
        check_eq("reset_res_data", res_data, 32'd0);
        check_eq("reset_job_err", job_err, 1'b0);
        reset_n = 1'b1;
        tick();

        bad_depth_job(32'd0);
        bad_depth_job(32'd129);
        run_job(2, 1'b1, 0, 16, 3, 32'h0000_007F, 1'b0, 1'b0, 1'b0);
        run_job(1, 1'b0, 6, 4, 0, $urandom, 1'b0, 1'b0, 1'b0);
        run_job(3, 1'b1, 5, 30, 1, $urandom, 1'b0, 1'b1, 1'b0);
        run_job(2, 1'b0, 40, 5, 2, $urandom, 1'b1, 1'b0, 1'b1);
        run_job(1, 1'b0, 2047, 3, 0, $urandom, 1'b0, 1'b0, 1'b0);
        run_job(128, 1'b1, 2047, 3, 1, $urandom, 1'b1, 1'b0, 1'b0);
        run_job(4, 1'b1, 0, 0, 0, $urandom, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++)
            run_job($urandom_range(1, 6), 1'($urandom), $urandom_range(0, 2047),
                    $urandom_range(0, 20), $urandom_range(0, 3), $urandom,
                    1'b1, 1'b0, 1'($urandom));
`ifdef CFU_SEQ_TIMEOUT_EN
        run_job(2, 1'b0, 0, 3, 1000, $urandom, 1'b0, 1'b0, 1'b0);
        run_job(1, 1'b0, 1, 2, 2, $urandom, 1'b0, 1'b0, 1'b0);
`endif
        reset_in_poll();
        bad_depth_job(shadow_m[1]);
        run_job(5, 1'b1, 100, 12, 2, $urandom, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
